// File: rtl/iter_ctrl.sv
// Job sequencer for an attached upcounter: clears it, steps it until ov, then pulses done.
// Optional abort/aborted ports are compiled in when ITER_CTRL_ABORT_EN is defined.
module iter_ctrl #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         start,
   input  logic         stall,
   input  logic [N-1:0] cnt_val,
   input  logic         cnt_ov,
`ifdef ITER_CTRL_ABORT_EN
   input  logic         abort,
   output logic         aborted,
`endif
   output logic         cnt_clr,
   output logic         cnten,
   output logic         ld,
   output logic         step,
   output logic         last,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Counter value seen on the final step: all ones below the MSB.
   localparam logic [N-1:0] LAST_VAL = {1'b0, {(N-1){1'b1}}};

   state_t state_reg;
   state_t state_next;
   logic   abort_now;

`ifdef ITER_CTRL_ABORT_EN
   logic aborted_reg;

   assign abort_now = abort;

   // Only a job that is actually running can be aborted; the pulse lands in the first IDLE cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         aborted_reg <= 1'b0;
      end else begin
         aborted_reg <= abort_now && ((state_reg == INIT) || (state_reg == RUN));
      end
   end

   assign aborted = aborted_reg;
`else
   assign abort_now = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_clr    = 1'b0;
      cnten      = 1'b0;
      ld         = 1'b0;
      step       = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = INIT;
            end
         end
         INIT: begin
            cnt_clr = 1'b1;
            ld      = 1'b1;
            busy    = 1'b1;
            state_next = abort_now ? IDLE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            // Priority: abort, then ov, then stall.
            if (abort_now) begin
               state_next = IDLE;
            end else if (cnt_ov) begin
               state_next = DONE;
            end else if (!stall) begin
               cnten = 1'b1;
               step  = 1'b1;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign last = step && (cnt_val == LAST_VAL);

endmodule

// File: tb/tb_iter_ctrl.sv
// Bench for iter_ctrl (N=4) wired to a behavioural 4-bit upcounter model.
module tb_iter_ctrl;

   localparam int N = 4;

   typedef struct {
      logic       clr;
      logic       start;
      logic       stall;
      logic [6:0] exp;      // {cnt_clr, cnten, ld, step, last, busy, done}
      logic       chk_cnt;
      logic [3:0] exp_cnt;
   } vec_t;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         start = 1'b0;
   logic         stall = 1'b0;
   logic [N-1:0] cnt_val;
   logic         cnt_ov;
   logic         cnt_clr, cnten, ld, step, last, busy, done;
   logic [6:0]   out_vec;
`ifdef ITER_CTRL_ABORT_EN
   logic         abort = 1'b0;
   logic         aborted;
`endif

   int total = 0;
   int bad   = 0;

   vec_t vecs[13];

   // Counter starts with ov set to show that IDLE ignores it and INIT clears it.
   logic [N-1:0] cnt = 4'd9;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (cnt_clr) cnt <= '0;
      else if (cnten) cnt <= cnt + 1'b1;
   end

   assign cnt_val = cnt;
   assign cnt_ov  = cnt[N-1];
   assign out_vec = {cnt_clr, cnten, ld, step, last, busy, done};

   iter_ctrl #(.N(N)) dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .stall   (stall),
      .cnt_val (cnt_val),
      .cnt_ov  (cnt_ov),
`ifdef ITER_CTRL_ABORT_EN
      .abort   (abort),
      .aborted (aborted),
`endif
      .cnt_clr (cnt_clr),
      .cnten   (cnten),
      .ld      (ld),
      .step    (step),
      .last    (last),
      .busy    (busy),
      .done    (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One job: cycle 0 is the IDLE cycle that samples start; cyc = cycles until done is seen.
   task automatic run_job(input bit hold, input int sa, input int sb,
                          output int cyc, output int steps, output int lasts);
      int run_idx;
      bit seen;
      steps = 0; lasts = 0; cyc = 0; run_idx = 0; seen = 0;
      @(negedge clk);
      start = 1'b1; stall = 1'b0;
      #1;
      chk("job_idle_busy", {31'd0, busy}, 0);
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         start = hold; stall = 1'b0;
         #1;
         if (busy && !ld) begin
            run_idx++;
            if (run_idx == sa || run_idx == sb) begin
               stall = 1'b1;
               #1;
               chk("stall_cnt", {28'd0, cnt_val}, sa - 1);
               chk("stall_step", {31'd0, step}, 0);
            end
         end
         chk("cnten_clr_excl", {31'd0, cnten & cnt_clr}, 0);
         steps += int'(step);
         lasts += int'(last);
         if (done) begin
            seen = 1'b1;
            cyc  = k;
         end
      end
      if (!seen) chk("job_timeout", 0, 1);
      $display("job hold=%0d stall=%0d/%0d cycles=%0d steps=%0d lasts=%0d", hold, sa, sb, cyc, steps, lasts);
   endtask

   initial begin
      int cyc, steps, lasts, dones;
      bit found;

      vecs[0]  = '{1'b0, 1'b1, 1'b0, 7'b0000000, 1'b0, 4'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 7'b1010010, 1'b0, 4'd0};
      for (int i = 0; i < 8; i++) begin
         vecs[2 + i] = '{1'b0, 1'b0, 1'b0, (i == 7) ? 7'b0101110 : 7'b0101010, 1'b1, 4'(i)};
      end
      vecs[10] = '{1'b0, 1'b0, 1'b0, 7'b0000010, 1'b1, 4'd8};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 7'b0000001, 1'b1, 4'd8};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 7'b0000000, 1'b0, 4'd0};

      // Reset for two cycles, then idle outputs must be quiet.
      clr = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b0;
      #1;
      chk("reset_outputs", {25'd0, out_vec}, 0);
      $display("reset out=%b", out_vec);

      // Single undisturbed job, cycle by cycle.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         clr = vecs[i].clr; start = vecs[i].start; stall = vecs[i].stall;
         #1;
         chk($sformatf("vec%0d_out", i), {25'd0, out_vec}, {25'd0, vecs[i].exp});
         if (vecs[i].chk_cnt) chk($sformatf("vec%0d_cnt", i), {28'd0, cnt_val}, {28'd0, vecs[i].exp_cnt});
         $display("vec %0d start=%b out=%b cnt=%0d", i, start, out_vec, cnt_val);
      end

      // Stalls on RUN cycles 3 and 4.
      run_job(1'b0, 3, 4, cyc, steps, lasts);
      chk("stall_steps", steps, 8);
      chk("stall_lasts", lasts, 1);
      chk("stall_latency", cyc, 13);

      // Start held high across two back-to-back jobs.
      run_job(1'b1, 0, 0, cyc, steps, lasts);
      chk("hold1_steps", steps, 8);
      chk("hold1_latency", cyc, 11);
      run_job(1'b1, 0, 0, cyc, steps, lasts);
      chk("hold2_steps", steps, 8);
      chk("hold2_lasts", lasts, 1);
      chk("hold2_latency", cyc, 11);
      @(negedge clk);
      start = 1'b0;

      // clr on the 5th step, mid-job.
      @(negedge clk);
      start = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (step && cnt_val == 4'd4) begin
            clr   = 1'b1;
            found = 1'b1;
         end
      end
      chk("clr_found_step5", {31'd0, found}, 1);
      @(negedge clk);
      clr = 1'b0;
      #1;
      chk("clr_idle_outputs", {25'd0, out_vec}, 0);
      dones = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         #1;
         dones += int'(done) + int'(busy);
      end
      chk("clr_no_done", dones, 0);
      $display("clr mid-job cnt=%0d", cnt_val);
      run_job(1'b0, 0, 0, cyc, steps, lasts);
      chk("after_clr_steps", steps, 8);
      chk("after_clr_lasts", lasts, 1);
      chk("after_clr_latency", cyc, 11);

`ifdef ITER_CTRL_ABORT_EN
      @(negedge clk);
      start = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (busy && !ld && cnt_val == 4'd3) begin
            abort = 1'b1;
            found = 1'b1;
            #1;
            chk("abort_cnten", {31'd0, cnten}, 0);
            chk("abort_step", {31'd0, step}, 0);
         end
      end
      chk("abort_found", {31'd0, found}, 1);
      @(negedge clk);
      abort = 1'b0;
      #1;
      chk("aborted_pulse", {31'd0, aborted}, 1);
      chk("abort_idle", {31'd0, busy}, 0);
      @(negedge clk);
      #1;
      chk("aborted_one_cycle", {31'd0, aborted}, 0);
      dones = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         dones += int'(done);
      end
      chk("abort_no_done", dones, 0);
      $display("abort at cnt=3 handled");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
